// File: rtl/matrix_load_ctrl.sv
// Matrix operand loader / result reader between the HPS word stream and the compute core.
// Operands arrive row-major, four int8 elements per 32-bit word, MSB first, and are
// packed into a fixed 5x5 layout. The core result is streamed back the same way.
module matrix_load_ctrl (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   input  logic [1:0]   cmd_size,
   output logic         cmd_ready,
   input  logic         wr_valid,
   input  logic [31:0]  wr_data,
   output logic         wr_ready,
   output logic [199:0] matrix1_out,
   output logic [199:0] matrix2_out,
   output logic         core_start,
   input  logic         core_done,
   input  logic [199:0] result_in,
   output logic         rd_valid,
   output logic [31:0]  rd_data,
   input  logic         rd_ready,
   output logic         busy
);

   localparam int unsigned MAT_W  = 200;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ELEM_W = 8;
   localparam int unsigned DIM    = 5;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned N_W    = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      READ   = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          size_q, size_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MAT_W-1:0]    mat_a_q, mat_a_d;
   logic [MAT_W-1:0]    mat_b_q, mat_b_d;
   logic [MAT_W-1:0]    res_q, res_d;
   logic [N_W-1:0]      n_dim;
   logic [CNT_W-1:0]    last_word;
   logic [WORD_W-1:0]   rd_data_d;

   logic                cmd_ready_q, wr_ready_q, busy_q, core_start_q, rd_valid_q;
   logic [WORD_W-1:0]   rd_data_q;

   // Pull stream word k out of a packed NxN matrix; bytes past N*N read as zero.
   function automatic logic [WORD_W-1:0] get_word(input logic [MAT_W-1:0] m,
                                                   input logic [CNT_W-1:0] k,
                                                   input logic [N_W-1:0]   n);
      logic [WORD_W-1:0] w;
      logic [4:0]        idx;
      int                pos;
      int                sel;
      w = '0;
      for (int r = 0; r < int'(DIM); r++) begin
         for (int c = 0; c < int'(DIM); c++) begin
            idx = 5'(r) * 5'(n) + 5'(c);
            pos = int'(MAT_W) - 1 - int'(ELEM_W) * (int'(DIM) * r + c);
            sel = int'(WORD_W) - 1 - int'(ELEM_W) * int'(idx[1:0]);
            if ((N_W'(r) < n) && (N_W'(c) < n) && (idx[4:2] == k))
               w[sel -: ELEM_W] = m[pos -: ELEM_W];
         end
      end
      return w;
   endfunction

   // Merge stream word k into a packed NxN matrix; bytes past N*N are dropped.
   function automatic logic [MAT_W-1:0] put_word(input logic [MAT_W-1:0]  m,
                                                  input logic [CNT_W-1:0]  k,
                                                  input logic [N_W-1:0]    n,
                                                  input logic [WORD_W-1:0] d);
      logic [MAT_W-1:0] o;
      logic [4:0]       idx;
      int               pos;
      int               sel;
      o = m;
      for (int r = 0; r < int'(DIM); r++) begin
         for (int c = 0; c < int'(DIM); c++) begin
            idx = 5'(r) * 5'(n) + 5'(c);
            pos = int'(MAT_W) - 1 - int'(ELEM_W) * (int'(DIM) * r + c);
            sel = int'(WORD_W) - 1 - int'(ELEM_W) * int'(idx[1:0]);
            if ((N_W'(r) < n) && (N_W'(c) < n) && (idx[4:2] == k))
               o[pos -: ELEM_W] = d[sel -: ELEM_W];
         end
      end
      return o;
   endfunction

   // Matrix order and index of the last stream word for the latched size.
   always_comb begin
      n_dim = N_W'(size_q) + N_W'(2);
      case (size_q)
         2'd0:    last_word = CNT_W'(0);
         2'd1:    last_word = CNT_W'(2);
         2'd2:    last_word = CNT_W'(3);
         default: last_word = CNT_W'(6);
      endcase
   end

   // Next-state and datapath updates for the load / compute / read sequence.
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      mat_a_d = mat_a_q;
      mat_b_d = mat_b_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               size_d  = cmd_size;
               mat_a_d = '0;
               mat_b_d = '0;
               cnt_d   = '0;
               state_d = LOAD_A;
            end
         end
         LOAD_A: begin
            if (wr_valid) begin
               mat_a_d = put_word(mat_a_q, cnt_q, n_dim, wr_data);
               if (cnt_q == last_word) begin
                  cnt_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LOAD_B: begin
            if (wr_valid) begin
               mat_b_d = put_word(mat_b_q, cnt_q, n_dim, wr_data);
               if (cnt_q == last_word) begin
                  cnt_d   = '0;
                  state_d = START;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (core_done) begin
               res_d   = result_in;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            if (rd_ready) begin
               if (cnt_q == last_word) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rd_data_d = (state_d == READ) ? get_word(res_d, cnt_d, n_dim) : '0;
   end

   // State, datapath and output registers; outputs follow the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         size_q       <= '0;
         cnt_q        <= '0;
         mat_a_q      <= '0;
         mat_b_q      <= '0;
         res_q        <= '0;
         cmd_ready_q  <= 1'b1;
         wr_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         cnt_q        <= cnt_d;
         mat_a_q      <= mat_a_d;
         mat_b_q      <= mat_b_d;
         res_q        <= res_d;
         cmd_ready_q  <= (state_d == IDLE);
         wr_ready_q   <= (state_d == LOAD_A) || (state_d == LOAD_B);
         busy_q       <= (state_d != IDLE);
         core_start_q <= (state_d == START);
         rd_valid_q   <= (state_d == READ);
         rd_data_q    <= rd_data_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign wr_ready    = wr_ready_q;
   assign busy        = busy_q;
   assign core_start  = core_start_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign matrix1_out = mat_a_q;
   assign matrix2_out = mat_b_q;

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Self-checking bench for matrix_load_ctrl: table-driven sizes, directed corner
// sequences and randomized operations checked against a stream-level model.
module tb_matrix_load_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic [1:0]   cmd_size;
   logic         cmd_ready;
   logic         wr_valid;
   logic [31:0]  wr_data;
   logic         wr_ready;
   logic [199:0] matrix1_out;
   logic [199:0] matrix2_out;
   logic         core_start;
   logic         core_done;
   logic [199:0] result_in;
   logic         rd_valid;
   logic [31:0]  rd_data;
   logic         rd_ready;
   logic         busy;

   int tests = 0;
   int fails = 0;
   int start_pulses = 0;

   logic [31:0]  a_w [7];
   logic [31:0]  b_w [7];
   logic [199:0] res_v;

   always #5 clk = ~clk;

   matrix_load_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_size(cmd_size), .cmd_ready(cmd_ready),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .matrix1_out(matrix1_out), .matrix2_out(matrix2_out),
      .core_start(core_start), .core_done(core_done), .result_in(result_in),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .busy(busy)
   );

   always @(negedge clk) if (core_start) start_pulses++;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: place the first N*N stream bytes row-major into the 5x5 grid.
   function automatic logic [199:0] model_pack(input int n, input bit use_b);
      logic [199:0] m;
      logic [31:0]  w;
      m = '0;
      for (int i = 0; i < n * n; i++) begin
         w = use_b ? b_w[i / 4] : a_w[i / 4];
         m[199 - 8 * (5 * (i / n) + (i % n)) -: 8] = w[31 - 8 * (i % 4) -: 8];
      end
      return m;
   endfunction

   // Reference: result stream word k, zero past the N*N-th element.
   function automatic logic [31:0] model_word(input int n, input int k);
      logic [31:0] w;
      int e;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         e = 4 * k + j;
         if (e < n * n) w[31 - 8 * j -: 8] = res_v[199 - 8 * (5 * (e / n) + (e % n)) -: 8];
      end
      return w;
   endfunction

   task automatic randomize_data(input bit rand_a);
      for (int i = 0; i < 7; i++) begin
         if (rand_a) a_w[i] = $urandom;
         b_w[i] = $urandom;
      end
      for (int i = 0; i < 6; i++) res_v[32 * i +: 32] = $urandom;
      res_v[199:192] = 8'($urandom);
   endtask

   // Accept a command; leaves the bench on the first LOAD_A negedge.
   task automatic start_cmd(input logic [1:0] s);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_size  = s;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_size  = 2'($urandom);
      chk("busy_after_cmd", busy, 1);
      chk("cmd_ready_after_cmd", cmd_ready, 0);
      chk("wr_ready_load_a", wr_ready, 1);
      chk("m1_cleared", matrix1_out, 0);
      chk("m2_cleared", matrix2_out, 0);
   endtask

   // Stream W words of A then W of B; mode 0 random gaps, 1 none, 2 alternate.
   task automatic load_all(input int w, input int mode);
      int  idx;
      int  cyc;
      bit  v;
      bit  rdy;
      idx = 0;
      cyc = 0;
      while (idx < 2 * w && cyc < 300) begin
         case (mode)
            0:       v = ($urandom_range(3, 0) != 0);
            1:       v = 1'b1;
            default: v = ((cyc % 2) == 0);
         endcase
         rdy = wr_ready;
         chk("no_start_during_load", core_start, 0);
         wr_valid = v;
         wr_data  = v ? ((idx < w) ? a_w[idx] : b_w[idx - w]) : $urandom;
         @(negedge clk);
         if (v && rdy) idx++;
         cyc++;
      end
      wr_valid = 1'b0;
      if (cyc >= 300) chk("load_timeout", 1, 0);
      chk("core_start_after_load", core_start, 1);
      chk("wr_ready_off_start", wr_ready, 0);
   endtask

   // From START: idle a few cycles in WAIT, then deliver the result.
   task automatic run_core(input logic [199:0] r);
      @(negedge clk);
      chk("core_start_one_cycle", core_start, 0);
      chk("busy_wait", busy, 1);
      chk("rd_valid_wait", rd_valid, 0);
      repeat ($urandom_range(3, 0)) begin
         result_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)};
         @(negedge clk);
      end
      core_done = 1'b1;
      result_in = r;
      @(negedge clk);
      core_done = 1'b0;
      result_in = '0;
   endtask

   // Drain W result words; mode 1 inserts random rd_ready stalls.
   task automatic read_all(input int n, input int w, input int mode);
      int k;
      int cyc;
      bit rdy;
      k = 0;
      cyc = 0;
      while (k < w && cyc < 300) begin
         chk("rd_valid_read", rd_valid, 1);
         chk($sformatf("rd_data_w%0d", k), rd_data, model_word(n, k));
         rdy = (mode == 0) ? 1'b1 : ($urandom_range(2, 0) != 0);
         rd_ready = rdy;
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      rd_ready = 1'b0;
      if (cyc >= 300) chk("read_timeout", 1, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_rd_data", rd_data, 0);
   endtask

   task automatic run_op(input logic [1:0] s, input int w, input int wmode, input int rmode,
                         input bit rand_a);
      int n;
      int p0;
      n = int'(s) + 2;
      randomize_data(rand_a);
      p0 = start_pulses;
      start_cmd(s);
      load_all(w, wmode);
      chk("m1_loaded", matrix1_out, model_pack(n, 1'b0));
      chk("m2_loaded", matrix2_out, model_pack(n, 1'b1));
      run_core(res_v);
      read_all(n, w, rmode);
      chk("single_start_pulse", 200'(start_pulses - p0), 1);
      chk("m1_hold", matrix1_out, model_pack(n, 1'b0));
      chk("m2_hold", matrix2_out, model_pack(n, 1'b1));
   endtask

   typedef struct {
      logic [1:0] size;
      int         words;
      int         wr_mode;
      int         rd_mode;
   } vec_t;

   vec_t vecs [6];
   int   p0;

   initial begin
      vecs[0] = '{2'd0, 1, 1, 0};
      vecs[1] = '{2'd1, 3, 1, 0};
      vecs[2] = '{2'd2, 4, 1, 0};
      vecs[3] = '{2'd3, 7, 1, 0};
      vecs[4] = '{2'd1, 3, 0, 1};
      vecs[5] = '{2'd3, 7, 2, 1};

      reset = 1'b1; cmd_valid = 1'b0; cmd_size = '0; wr_valid = 1'b0; wr_data = '0;
      core_done = 1'b0; result_in = '0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_m1", matrix1_out, 0);
      chk("rst_m2", matrix2_out, 0);

      // Size table
      for (int i = 0; i < 6; i++) run_op(vecs[i].size, vecs[i].words, vecs[i].wr_mode, vecs[i].rd_mode, 1'b1);

      // N=4 known A words
      a_w[0] = 32'h01020304; a_w[1] = 32'h05060708; a_w[2] = 32'h090A0B0C; a_w[3] = 32'h0D0E0F10;
      run_op(2'd2, 4, 1, 0, 1'b0);
      chk("n4_row0", 200'(matrix1_out[199:168]), 200'(32'h01020304));
      chk("n4_pad0", 200'(matrix1_out[167:160]), 0);
      chk("n4_row1", 200'(matrix1_out[159:128]), 200'(32'h05060708));
      chk("n4_tail", 200'(matrix1_out[47:0]), 0);

      // N=3 with discarded trailing bytes
      a_w[0] = 32'h01020304; a_w[1] = 32'h05060708; a_w[2] = 32'h09AABBCC;
      run_op(2'd1, 3, 0, 1, 1'b0);
      chk("n3_e22", 200'(matrix1_out[103:96]), 200'(8'h09));
      chk("n3_tail_zero", 200'(matrix1_out[95:0]), 0);
      chk("n3_col3_zero", 200'(matrix1_out[175:160]), 0);

      // N=2 result held under rd_ready stall
      randomize_data(1'b1);
      res_v = '0;
      res_v[199:192] = 8'h11; res_v[191:184] = 8'h22; res_v[159:152] = 8'h33; res_v[151:144] = 8'h44;
      start_cmd(2'd0);
      load_all(1, 1);
      run_core(res_v);
      for (int i = 0; i < 5; i++) begin
         chk("stall_rd_valid", rd_valid, 1);
         chk("stall_rd_data", rd_data, 200'(32'h11223344));
         @(negedge clk);
      end
      rd_ready = 1'b1;
      chk("final_rd_data", rd_data, 200'(32'h11223344));
      @(negedge clk);
      rd_ready = 1'b0;
      chk("n2_done_busy", busy, 0);
      chk("n2_done_rd_valid", rd_valid, 0);

      // Reset mid LOAD_B
      randomize_data(1'b1);
      start_cmd(2'd2);
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1;
         wr_data  = (i < 4) ? a_w[i] : b_w[i - 4];
         @(negedge clk);
      end
      wr_valid = 1'b0;
      chk("midb_wr_ready", wr_ready, 1);
      reset = 1'b1;
      p0 = start_pulses;
      @(negedge clk);
      reset = 1'b0;
      chk("midb_busy", busy, 0);
      chk("midb_cmd_ready", cmd_ready, 1);
      chk("midb_m1", matrix1_out, 0);
      chk("midb_m2", matrix2_out, 0);
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = $urandom;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      chk("midb_no_start", 200'(start_pulses - p0), 0);
      chk("midb_no_rd_valid", rd_valid, 0);
      chk("midb_still_idle", busy, 0);

      // Stray core_done in LOAD_A and cmd_valid in WAIT
      randomize_data(1'b1);
      p0 = start_pulses;
      start_cmd(2'd0);
      core_done = 1'b1;
      result_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 8'($urandom)};
      @(negedge clk);
      core_done = 1'b0;
      chk("stray_done_wr_ready", wr_ready, 1);
      chk("stray_done_rd_valid", rd_valid, 0);
      load_all(1, 1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_size  = 2'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("stray_cmd_cmd_ready", cmd_ready, 0);
      chk("stray_cmd_busy", busy, 1);
      chk("stray_cmd_wr_ready", wr_ready, 0);
      chk("stray_cmd_rd_valid", rd_valid, 0);
      core_done = 1'b1;
      result_in = res_v;
      @(negedge clk);
      core_done = 1'b0;
      read_all(2, 1, 1);
      chk("stray_single_start", 200'(start_pulses - p0), 1);
      chk("stray_m1", matrix1_out, model_pack(2, 1'b0));

      // Randomized operations
      for (int i = 0; i < 30; i++) begin
         logic [1:0] s;
         int         w;
         s = 2'($urandom_range(3, 0));
         case (s)
            2'd0:    w = 1;
            2'd1:    w = 3;
            2'd2:    w = 4;
            default: w = 7;
         endcase
         run_op(s, w, int'($urandom_range(2, 0)), int'($urandom_range(1, 0)), 1'b1);
         repeat ($urandom_range(2, 0)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/matrix_load_ctrl.md
MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port cmd_valid  input  1  HPS requests a new operation.
REQ-004 SHALL have port cmd_size  input  2  matrix order: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-006 SHALL have port wr_valid  input  1  HPS operand word valid.
REQ-007 SHALL have port wr_data  input  32  four int8 elements, first element in [31:24].
REQ-008 SHALL have port wr_ready  output  1  high only in LOAD_A and LOAD_B.
REQ-009 SHALL have port matrix1_out  output  200  operand A, packed 5x5 layout.
REQ-010 SHALL have port matrix2_out  output  200  operand B, packed 5x5 layout.
REQ-011 SHALL have port core_start  output  1  one-cycle start pulse to the compute core.
REQ-012 SHALL have port core_done  input  1  core result valid on result_in this cycle.
REQ-013 SHALL have port result_in  input  200  core result, packed 5x5 layout.
REQ-014 SHALL have port rd_valid  output  1  result word valid.
REQ-015 SHALL have port rd_data  output  32  four result elements, first in [31:24].
REQ-016 SHALL have port rd_ready  input  1  HPS accepts result word.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 Packed layout SHALL place element (r,c), 0<=r,c<=4, at bits [199-8*(5r+c) -: 8]; positions with r>=N or c>=N SHALL be zero.
REQ-019 Stream order SHALL be row-major over the NxN elements; words per matrix W = ceil(N*N/4): N=2->1, 3->3, 4->4, 5->7; unused trailing bytes of the last word SHALL be ignored on write and zero on read.
REQ-020 Each matrix SHALL start on a fresh word; B SHALL never share a word with A.
REQ-021 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT, READ.
REQ-022 IDLE: on cmd_valid, latch cmd_size, clear matrix1_out and matrix2_out to zero, reset word counter, go to LOAD_A.
REQ-023 A word SHALL be accepted only on a cycle with wr_valid and wr_ready both high; the counter advances by one per accepted word.
REQ-024 LOAD_A: after accepting word W-1 go to LOAD_B with counter cleared; LOAD_B: after word W-1 go to START.
REQ-025 START SHALL last exactly one cycle with core_start=1, then go to WAIT; core_start SHALL be 0 in all other states.
REQ-026 WAIT: on the cycle core_done=1, register result_in internally and go to READ with counter cleared; core_done in any other state SHALL be ignored.
REQ-027 READ: rd_valid=1; rd_data SHALL be result word k (same layout as REQ-019) from the registered result; advance k on rd_valid&&rd_ready; after word W-1 accepted go to IDLE.
REQ-028 rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-029 matrix1_out and matrix2_out SHALL hold their values from LOAD_B exit until the next command accepted in IDLE.
REQ-030 cmd_valid outside IDLE SHALL be ignored; cmd_size changes after acceptance SHALL have no effect.
REQ-031 Minimum latency for N=2 with no stalls: cmd accept cycle T, A word T+1, B word T+2, core_start at T+3.

Reset
REQ-032 While reset=1 at a clock edge: state=IDLE, counters=0, matrix1_out=matrix2_out=0, stored result=0, core_start=0, rd_valid=0, rd_data=0, wr_ready=0, busy=0, cmd_ready=1 after the edge.
REQ-033 Reset asserted in any state, including mid-load or mid-read, SHALL abandon the operation with no further core_start or rd_valid until a new command.

Verification
REQ-034 N=4, A words 0x01020304,0x05060708,0x090A0B0C,0x0D0E0F10 -> matrix1_out[199:168]=0x01020304, [167:160]=0, [159:128]=0x05060708, [47:0]=0.
REQ-035 N=3, A words 0x01020304,0x05060708,0x09AABBCC -> element (2,2)=0x09 at [103:96]; bytes AA,BB,CC discarded; row 3 and column 3+ zero.
REQ-036 N=5, 7 words per operand with wr_valid toggled every other cycle -> exactly 14 words accepted, single core_start pulse one cycle after the 14th.
REQ-037 N=2, result_in with (0,0..1)=0x11,0x22 and (1,0..1)=0x33,0x44 on core_done -> single rd_data=0x11223344; holding rd_ready=0 for 5 cycles keeps it stable.
REQ-038 Reset during LOAD_B after 2 of 4 words -> next cycle busy=0, cmd_ready=1, both matrix outputs zero, no core_start.
REQ-039 cmd_valid pulsed during WAIT and core_done pulsed during LOAD_A -> both ignored; state sequence unchanged.
